// File: rtl/wb_sensor_gpio.sv
`default_nettype none
// wb_sensor_gpio: Wishbone GPIO with 2-flop sync, tick-based debounce, per-channel
// edge select and a maskable level interrupt. Rev 1.0
module wb_sensor_gpio #(
  parameter int              N_CH    = 16,
  parameter int              DEB_CNT = 4,
  parameter int              DIV_W   = 16,
  parameter logic [N_CH-1:0] OUT_RST = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     wb_adr_i,
  input  logic [31:0]     wb_dat_i,
  output logic [31:0]     wb_dat_o,
  input  logic [3:0]      wb_sel_i,
  input  logic            wb_stb_i,
  input  logic            wb_cyc_i,
  input  logic            wb_we_i,
  output logic            wb_ack_o,
  output logic            intr,
  input  logic [N_CH-1:0] gpio_in,
  output logic [N_CH-1:0] gpio_out,
  output logic [N_CH-1:0] gpio_oe
);

  localparam logic [3:0] DEB_LIM = 4'(DEB_CNT);

  logic            ack_q;
  logic [31:0]     dat_q;
  logic            intr_q;
  logic [N_CH-1:0] out_q, oe_q, en_q, pend_q, pol_q, both_q;
  logic [N_CH-1:0] sync1_q, sync2_q, in_q, in_d;
  logic [DIV_W-1:0] div_q, pre_q;

  logic            acc, wr, tick;
  logic [2:0]      reg_sel;
  logic [N_CH-1:0] ch_mask, rise, fall, evt, w1c;
  logic [DIV_W-1:0] div_mask;
  logic [31:0]     rdata;
  logic            unused_bits;

  assign acc     = wb_stb_i & wb_cyc_i & ~ack_q;
  assign wr      = acc & wb_we_i;
  assign reg_sel = wb_adr_i[4:2];
  assign tick    = (pre_q == div_q);
  assign unused_bits = ^{wb_adr_i[31:5], wb_adr_i[1:0], wb_dat_i, wb_sel_i};

  // Byte enables expanded to per-bit masks for the narrow registers.
  always_comb begin
    ch_mask  = '0;
    div_mask = '0;
    for (int i = 0; i < N_CH; i++) ch_mask[i] = wb_sel_i[i/8];
    for (int i = 0; i < DIV_W; i++) div_mask[i] = wb_sel_i[i/8];
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      3'd0: rdata[N_CH-1:0]  = in_q;
      3'd1: rdata[N_CH-1:0]  = out_q;
      3'd2: rdata[N_CH-1:0]  = oe_q;
      3'd3: rdata[N_CH-1:0]  = en_q;
      3'd4: rdata[N_CH-1:0]  = pend_q;
      3'd5: rdata[N_CH-1:0]  = pol_q;
      3'd6: rdata[N_CH-1:0]  = both_q;
      3'd7: rdata[DIV_W-1:0] = div_q;
    endcase
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [3:0] cnt_q, cnt_d;
    logic       in_nx;

    always_comb begin
      cnt_d = cnt_q;
      in_nx = in_q[g];
      if (tick) begin
        if (sync2_q[g] == in_q[g]) begin
          cnt_d = '0;
        end else if (cnt_q + 4'd1 == DEB_LIM) begin
          cnt_d = '0;
          in_nx = sync2_q[g];
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
    end

    assign in_d[g] = in_nx;

    always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
    end
  end

  assign rise = in_d & ~in_q;
  assign fall = ~in_d & in_q;
  assign evt  = (both_q & (rise | fall)) | (rise & ~pol_q) | (fall & pol_q);
  assign w1c  = (wr && reg_sel == 3'd4) ? (wb_dat_i[N_CH-1:0] & ch_mask) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q   <= 1'b0;
      dat_q   <= '0;
      intr_q  <= 1'b0;
      out_q   <= OUT_RST;
      oe_q    <= '0;
      en_q    <= '0;
      pend_q  <= '0;
      pol_q   <= '0;
      both_q  <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      in_q    <= '0;
      div_q   <= '0;
      pre_q   <= '0;
    end else begin
      ack_q   <= acc;
      intr_q  <= |(pend_q & en_q);
      sync1_q <= gpio_in;
      sync2_q <= sync1_q;
      in_q    <= in_d;
      // A new event overrides a simultaneous write-one-to-clear.
      pend_q  <= (pend_q & ~w1c) | evt;
      pre_q   <= tick ? '0 : pre_q + DIV_W'(1);
      if (acc) dat_q <= rdata;
      if (wr) begin
        case (reg_sel)
          3'd1: out_q  <= (out_q  & ~ch_mask) | (wb_dat_i[N_CH-1:0] & ch_mask);
          3'd2: oe_q   <= (oe_q   & ~ch_mask) | (wb_dat_i[N_CH-1:0] & ch_mask);
          3'd3: en_q   <= (en_q   & ~ch_mask) | (wb_dat_i[N_CH-1:0] & ch_mask);
          3'd5: pol_q  <= (pol_q  & ~ch_mask) | (wb_dat_i[N_CH-1:0] & ch_mask);
          3'd6: both_q <= (both_q & ~ch_mask) | (wb_dat_i[N_CH-1:0] & ch_mask);
          3'd7: begin
            div_q <= (div_q & ~div_mask) | (wb_dat_i[DIV_W-1:0] & div_mask);
            pre_q <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign intr     = intr_q;
  assign gpio_out = out_q;
  assign gpio_oe  = oe_q;

endmodule
`default_nettype wire
